// File: rtl/box_overlay_pkg.sv
// box_overlay_pkg: coordinate/box types, FSM states and display defaults shared by the overlay
package box_overlay_pkg;
  localparam int H_ACT_DEF = 480;
  localparam int V_ACT_DEF = 272;
  typedef logic [9:0] coord_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
  } box_t;
  typedef enum logic {EMPTY, ACTIVE} ov_state_t;
  function automatic box_t unpack(input logic [19:0] v);
    return box_t'(v);
  endfunction
endpackage

// File: rtl/box_border_cmp.sv
// box_border_cmp: combinational test for whether (x,y) lies on a box outline THICK pixels wide
module box_border_cmp
  import box_overlay_pkg::*;
#(
  parameter int THICK = 2
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  box_t       lt,
  input  box_t       rd,
  output logic       border
);
  localparam logic [10:0] T = 11'(THICK);
  logic in_box, inner;
  // widened by one bit so x+THICK near the right edge cannot wrap
  always_comb begin
    in_box = lt.x <= x && x <= rd.x && lt.y <= y && y <= rd.y;
    inner = {1'b0, lt.x} + T <= {1'b0, x} && {1'b0, x} + T <= {1'b0, rd.x} &&
            {1'b0, lt.y} + T <= {1'b0, y} && {1'b0, y} + T <= {1'b0, rd.y};
    border = in_box && !inner;
  end
endmodule

// File: rtl/box_overlay.sv
// box_overlay: draws a frame-synchronous rectangular outline onto a live RGB pixel stream
module box_overlay
  import box_overlay_pkg::*;
#(
  parameter int          H_ACT          = H_ACT_DEF,
  parameter int          V_ACT          = V_ACT_DEF,
  parameter int          THICK          = 2,
  parameter logic [23:0] BOX_RGB        = 24'hFF0000,
  parameter int          TIMEOUT_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  loc_x,
  input  logic [9:0]  loc_y,
  input  logic        in_de,
  input  logic [23:0] in_rgb,
  input  logic [19:0] box_lt,
  input  logic [19:0] box_rd,
  input  logic        box_update,
  output logic        out_de,
  output logic [23:0] out_rgb,
  output logic        box_active
);
  localparam coord_t X_MAX = coord_t'(H_ACT - 1);
  localparam coord_t Y_MAX = coord_t'(V_ACT - 1);
  box_t pend_lt, pend_rd, act_lt, act_rd, src_lt, src_rd;
  logic pend_flag, frame_end, load, border, border_d1, de_d1;
  logic [23:0] rgb_d1;
  logic [15:0] tcnt, tnext;
  ov_state_t state;
  function automatic box_t clamp(input box_t b);
    return {b.x > X_MAX ? X_MAX : b.x, b.y > Y_MAX ? Y_MAX : b.y};
  endfunction
  box_border_cmp #(.THICK(THICK)) u_cmp (
    .x(loc_x), .y(loc_y), .lt(act_lt), .rd(act_rd), .border(border)
  );
  // a box arriving in the frame-end cycle itself overrides the pending one
  always_comb begin
    frame_end = in_de && loc_x == X_MAX && loc_y == Y_MAX;
    src_lt = box_update ? unpack(box_lt) : pend_lt;
    src_rd = box_update ? unpack(box_rd) : pend_rd;
    load = frame_end && (pend_flag || box_update);
    tnext = tcnt == '1 ? tcnt : tcnt + 16'd1;
  end
  assign box_active = state == ACTIVE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_lt <= '0;
      pend_rd <= '0;
      pend_flag <= 1'b0;
      act_lt <= '0;
      act_rd <= '0;
      tcnt <= '0;
      state <= EMPTY;
      border_d1 <= 1'b0;
      rgb_d1 <= '0;
      de_d1 <= 1'b0;
      out_rgb <= '0;
      out_de <= 1'b0;
    end else begin
      if (box_update) begin
        pend_lt <= unpack(box_lt);
        pend_rd <= unpack(box_rd);
      end
      pend_flag <= load ? 1'b0 : pend_flag || box_update;
      if (load) begin
        act_lt <= clamp(src_lt);
        act_rd <= clamp(src_rd);
        tcnt <= '0;
        state <= src_lt.x <= src_rd.x && src_lt.y <= src_rd.y ? ACTIVE : EMPTY;
      end else if (frame_end && state == ACTIVE) begin
        tcnt <= tnext;
        if (TIMEOUT_FRAMES != 0 && tnext == 16'(TIMEOUT_FRAMES)) state <= EMPTY;
      end
      border_d1 <= border && in_de && state == ACTIVE;
      rgb_d1 <= in_rgb;
      de_d1 <= in_de;
      out_rgb <= border_d1 ? BOX_RGB : rgb_d1;
      out_de <= de_d1;
    end
  end
endmodule

// File: tb/tb_box_overlay.sv
// tb_box_overlay: directed sparse-frame stimulus checked against a behavioural overlay model
module tb_box_overlay;
  import box_overlay_pkg::*;
  localparam int TO = 3;
  localparam int TK = 2;
  localparam logic [23:0] RED = 24'hFF0000;
  logic clk = 0, rst = 1, in_de = 0, box_update = 0;
  logic [9:0] loc_x = 0, loc_y = 0;
  logic [23:0] in_rgb = 0, out_rgb;
  logic [19:0] box_lt = 0, box_rd = 0;
  logic out_de, box_active, ref_b;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  box_overlay #(.THICK(TK), .TIMEOUT_FRAMES(TO)) dut (
    .clk(clk), .rst(rst), .loc_x(loc_x), .loc_y(loc_y), .in_de(in_de), .in_rgb(in_rgb),
    .box_lt(box_lt), .box_rd(box_rd), .box_update(box_update),
    .out_de(out_de), .out_rgb(out_rgb), .box_active(box_active)
  );
  typedef struct {
    bit p_ok;
    int plx, ply, prx, pry;
    bit on;
    int alx, aly, arx, ary, frames;
  } mdl_t;
  mdl_t m;
  bit e1_de, e2_de;
  logic [23:0] e1_rgb, e2_rgb;
  box_t mlt, mrd;
  assign mlt = {10'(m.alx), 10'(m.aly)};
  assign mrd = {10'(m.arx), 10'(m.ary)};
  box_border_cmp #(.THICK(TK)) ref_cmp (.x(loc_x), .y(loc_y), .lt(mlt), .rd(mrd), .border(ref_b));
  // a pixel is on the outline when it is inside the box and closer than TK to some edge
  function automatic bit on_outline(input mdl_t s, input int x, input int y);
    int d;
    if (!s.on || x < s.alx || x > s.arx || y < s.aly || y > s.ary) return 0;
    d = x - s.alx;
    if (s.arx - x < d) d = s.arx - x;
    if (y - s.aly < d) d = y - s.aly;
    if (s.ary - y < d) d = s.ary - y;
    return d < TK;
  endfunction
  function automatic mdl_t step(input mdl_t s);
    mdl_t n = s;
    if (box_update) begin
      n.p_ok = 1;
      n.plx = int'(box_lt[19:10]); n.ply = int'(box_lt[9:0]);
      n.prx = int'(box_rd[19:10]); n.pry = int'(box_rd[9:0]);
    end
    if (in_de && loc_x == 479 && loc_y == 271) begin
      if (n.p_ok) begin
        n.p_ok = 0;
        n.on = n.plx <= n.prx && n.ply <= n.pry;
        n.alx = n.plx < 479 ? n.plx : 479; n.aly = n.ply < 271 ? n.ply : 271;
        n.arx = n.prx < 479 ? n.prx : 479; n.ary = n.pry < 271 ? n.pry : 271;
        n.frames = 0;
      end else if (n.on) begin
        n.frames++;
        if (n.frames == TO) n.on = 0;
      end
    end
    return n;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '{default: 0};
      e1_de <= 0; e2_de <= 0; e1_rgb <= '0; e2_rgb <= '0;
    end else begin
      e1_de <= in_de;
      e1_rgb <= (in_de && on_outline(m, int'(loc_x), int'(loc_y))) ? RED : in_rgb;
      e2_de <= e1_de;
      e2_rgb <= e1_rgb;
      m <= step(m);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    chk("pipe_de", 32'(out_de), 32'(e2_de));
    chk("pipe_rgb", 32'(out_rgb), 32'(e2_rgb));
  end
  function automatic logic [19:0] pk(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction
  task automatic cyc(input bit de, input int x, input int y, input logic [23:0] rgb,
                     input bit upd = 0, input logic [19:0] lt = 0, input logic [19:0] rd = 0);
    in_de = de; loc_x = 10'(x); loc_y = 10'(y); in_rgb = rgb;
    box_update = upd; box_lt = lt; box_rd = rd;
    #1;
    if (de && m.on) chk("ref_cmp", 32'(ref_b), 32'(on_outline(m, x, y)));
    @(negedge clk);
  endtask
  task automatic fe(input bit upd = 0, input logic [19:0] lt = 0, input logic [19:0] rd = 0);
    cyc(1, 479, 271, 24'h0A0B0C, upd, lt, rd);
  endtask
  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) cyc(1, x, y, 24'($urandom));
      cyc(0, x0, y, 24'h0000AA);
    end
  endtask
  // hand-computed literal: pixel colour two cycles after it enters
  task automatic pin(input string nm, input int x, input int y, input bit red);
    logic [23:0] c;
    c = 24'(x * 256 + y) | 24'h010000;
    cyc(1, x, y, c);
    cyc(0, x, y, 24'h0000AA);
    chk({nm, "_de"}, 32'(out_de), 1);
    chk(nm, 32'(out_rgb), 32'(red ? RED : c));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_active", 32'(box_active), 0);
    chk("rst_de", 32'(out_de), 0);
    chk("rst_rgb", 32'(out_rgb), 0);
    scan(95, 105, 78, 82);
    pin("f0_pass", 100, 80, 0);
    fe();
    chk("f0_active", 32'(box_active), 0);
    scan(98, 102, 79, 80);
    cyc(1, 150, 60, 24'h00FF00, 1, pk(100, 50), pk(200, 120));
    pin("fa_cur", 100, 80, 0);
    pin("fa_cur2", 150, 50, 0);
    chk("fa_pending", 32'(box_active), 0);
    fe();
    chk("fa_loaded", 32'(box_active), 1);
    pin("fb_100_80", 100, 80, 1);
    pin("fb_101_80", 101, 80, 1);
    pin("fb_102_80", 102, 80, 0);
    pin("fb_200_120", 200, 120, 1);
    pin("fb_150_50", 150, 50, 1);
    pin("fb_150_52", 150, 52, 0);
    scan(98, 104, 48, 53);
    scan(196, 202, 117, 122);
    fe();
    cyc(1, 20, 20, 24'h111111, 1, pk(279, 471), pk(0, 0));
    fe();
    chk("inv_active", 32'(box_active), 0);
    pin("inv_100_80", 100, 80, 0);
    pin("inv_150_50", 150, 50, 0);
    scan(98, 103, 48, 52);
    fe();
    cyc(1, 1, 1, 24'h222222, 1, pk(10, 10), pk(20, 20));
    scan(8, 12, 9, 11);
    cyc(1, 2, 2, 24'h333333, 1, pk(30, 30), pk(40, 40));
    fe(1, pk(300, 200), pk(310, 205));
    chk("two_active", 32'(box_active), 1);
    pin("two_10_10", 10, 10, 0);
    pin("two_30_30", 30, 30, 0);
    pin("two_300_200", 300, 200, 1);
    pin("two_301_201", 301, 201, 1);
    pin("two_305_202", 305, 202, 0);
    scan(298, 312, 199, 206);
    cyc(1, 3, 3, 24'h444444, 1, pk(470, 265), pk(900, 900));
    fe();
    for (int k = 1; k <= TO; k++) begin
      pin("to_478_270", 478, 270, 1);
      pin("to_474_270", 474, 270, 1);
      pin("to_474_268", 474, 268, 0);
      chk("to_active", 32'(box_active), 1);
      fe();
    end
    chk("to_dropped", 32'(box_active), 0);
    pin("to_clean", 478, 270, 0);
    cyc(1, 4, 4, 24'h555555, 1, pk(5, 5), pk(5, 5));
    fe();
    pin("one_5_5", 5, 5, 1);
    pin("one_6_5", 6, 5, 0);
    pin("one_5_4", 5, 4, 0);
    cyc(1, 4, 4, 24'h555555, 1, pk(50, 60), pk(52, 61));
    fe();
    pin("small_51_60", 51, 60, 1);
    pin("small_51_61", 51, 61, 1);
    scan(48, 54, 59, 62);
    pin("pre_rst", 51, 60, 1);
    in_de = 1; loc_x = 52; loc_y = 60; in_rgb = 24'h777777;
    #2 rst = 1;
    #1;
    chk("mid_rst_de", 32'(out_de), 0);
    chk("mid_rst_rgb", 32'(out_rgb), 0);
    chk("mid_rst_active", 32'(box_active), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    pin("post_rst", 51, 60, 0);
    fe();
    pin("post_rst_fe", 51, 60, 0);
    chk("post_rst_active", 32'(box_active), 0);
    cyc(1, 9, 9, 24'h888888, 1, pk(50, 60), pk(52, 61));
    pin("reload_pending", 51, 60, 0);
    fe();
    pin("reload_drawn", 51, 60, 1);
    repeat (4) cyc(0, 0, 0, 24'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/box_overlay.md
Name: box_overlay

Overview:
- Draws a rectangular outline onto the live RGB pixel stream of the 480x272 display path.
- Consumes the packed bounding box produced by the threshold scanner (lt/rd corners, {x,y} packing) at the far end of the image pipeline.
- Latches each new box and applies it only at frame end, so an outline never tears mid-frame.
- Clears the box after a configurable number of frames with no update.

Parameters:
- H_ACT, 480, active pixels per line.
- V_ACT, 272, active lines per frame.
- THICK, 2, outline thickness in pixels (1..15).
- BOX_RGB, 24'hFF0000, outline colour.
- TIMEOUT_FRAMES, 30, frames without box_update before the box is dropped; 0 disables the timeout.

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous, active-high reset
- loc_x  input  10  current pixel column
- loc_y  input  10  current pixel row
- in_de  input  1  input pixel valid
- in_rgb  input  24  input pixel {R,G,B}
- box_lt  input  20  top-left corner {x[19:10], y[9:0]}
- box_rd  input  20  bottom-right corner {x[19:10], y[9:0]}
- box_update  input  1  one-cycle pulse: box_lt/box_rd valid this cycle
- out_de  output  1  in_de delayed 2 cycles
- out_rgb  output  24  overlaid pixel, aligned with out_de
- box_active  output  1  high while a box is being drawn

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Reset clears out_de, out_rgb, box_active, the pending and active registers, the timeout counter and the FSM (EMPTY).
- Pending capture: box_update loads pend_lt/pend_rd and sets pend_flag. A second pulse before frame end overwrites the pending box; the last one wins.
- Frame end condition: in_de && loc_x==H_ACT-1 && loc_y==V_ACT-1.
- At frame end with pend_flag set, or with box_update in that same cycle (incoming values take priority):
  - copy the box to act_lt/act_rd and clear pend_flag;
  - reset the timeout counter;
  - enter ACTIVE if lt_x<=rd_x && lt_y<=rd_y, otherwise enter EMPTY (an inverted box means no object was found).
- At frame end with no pending box:
  - in ACTIVE, increment the timeout counter;
  - when the count reaches TIMEOUT_FRAMES (nonzero), go to EMPTY;
  - the counter saturates and does not wrap.
- FSM states: EMPTY, ACTIVE. box_active = (state==ACTIVE), registered, and changes on the cycle after frame end.
- Clamping: act coordinates above H_ACT-1 / V_ACT-1 are clamped when loaded.
- Border test, stage 1 (registered):
  - in_box = lt_x<=x<=rd_x && lt_y<=y<=rd_y;
  - inner = lt_x+THICK<=x && x+THICK<=rd_x && lt_y+THICK<=y && y+THICK<=rd_y;
  - compute at 11-bit width, no underflow;
  - border = in_box && !inner && ACTIVE;
  - in_rgb, in_de and border are carried forward.
- Stage 2 (registered): out_rgb = border ? BOX_RGB : rgb_d1; out_de = de_d1.
- Latency: fixed 2 cycles, in_de -> out_de, with or without a box.
- Small box: a box narrower or shorter than 2*THICK is drawn fully filled.
- Single-pixel box (lt==rd): draws that one pixel.
- When in_de is low: outputs still pipeline; out_rgb follows rgb_d1 with no border, and border is forced 0.
- Mid-frame reset: outputs go to 0 immediately; drawing resumes only after the next box_update and frame end.

Decomposition:
- Package box_overlay_pkg holds:
  - typedef coord_t (logic [9:0]);
  - typedef box_t (struct {coord_t x, y});
  - enum ov_state_t {EMPTY, ACTIVE};
  - H_ACT/V_ACT defaults;
  - unpack function {x,y} -> box_t.
- One sub-module, box_border_cmp: a purely combinational border test on (x, y, lt, rd, THICK). It is instanced in stage 1 and reused by the bench's reference model.

Test Plan:
- Reset then stream a frame with no update -> out_rgb==in_rgb everywhere, out_de==in_de delayed 2, box_active=0.
- box_update lt=(100,50) rd=(200,120) mid-frame -> current frame unchanged; next frame:
  - red at (100,80), (101,80), (200,120), (150,50);
  - pass-through at (102,80) and (150,52).
- Inverted box lt=(279,471) rd=(0,0) -> EMPTY after frame end, no red pixels, box_active=0.
- Two updates in one frame, then an update in the frame-end cycle -> only the frame-end box is drawn next frame.
- TIMEOUT_FRAMES=3, one update, then none -> drawn for 3 frames, box_active drops at the 3rd frame end, 4th frame clean.
- Assert rst mid-line while ACTIVE -> out_de/out_rgb 0 the same cycle; after release no box until a new update and frame end.
